// File: rtl/ours_axi4_b_rr_resp_router.sv
// Routes returning AXI4 B beats to the write master whose AW was granted, in AW order.
// Head-of-queue B stalls until its owner is ready; AW push is back-pressured once the tracker is full.

module icg #(
    parameter int BACKEND_DOMAIN = 0
) (
    input  logic clk,
    input  logic en,
    input  logic tst_en,
    output logic clkg
);
    logic en_lat;

    if (BACKEND_DOMAIN < 0) begin : g_bad_domain
        $error("icg: BACKEND_DOMAIN must be non-negative");
    end

    // Enable is captured while clk is low so clkg cannot glitch during the high phase.
    always_latch begin
        if (!clk) en_lat = en | tst_en;
    end

    assign clkg = clk & en_lat;
endmodule

module ours_axi4_b_rr_resp_router #(
    parameter int BACKEND_DOMAIN  = 0,
    parameter int N_INPUT         = 2,
    parameter int B_WIDTH         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             aw_push,
    input  logic [N_INPUT-1:0]               aw_src,
    output logic                             aw_push_rdy,
    input  logic                             master_bvld,
    input  logic [B_WIDTH-1:0]               master_b,
    output logic                             master_brdy,
    output logic [N_INPUT-1:0]               slave_bvld,
    output logic [N_INPUT-1:0][B_WIDTH-1:0]  slave_b,
    input  logic [N_INPUT-1:0]               slave_brdy,
    output logic [CNT_W-1:0]                 outstanding,
    output logic                             err_unexp_b,
    output logic                             err_bad_src,
    output logic                             clk_en
);
    localparam int IDX_W = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    if (N_INPUT < 1) begin : g_bad_n
        $error("N_INPUT must be >= 1");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_depth
        $error("MAX_OUTSTANDING must be >= 1");
    end

    logic             clkg;
    logic [IDX_W-1:0] mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             push_acc;
    logic             pop;
    logic [IDX_W-1:0] src_idx;
    logic [IDX_W-1:0] head;
    logic [N_INPUT-1:0] head_oh;

    assign clk_en = ~rstn | aw_push | ~empty | master_bvld;

    icg #(
        .BACKEND_DOMAIN(BACKEND_DOMAIN)
    ) u_icg (
        .clk    (clk),
        .en     (clk_en),
        .tst_en (1'b0),
        .clkg   (clkg)
    );

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(MAX_OUTSTANDING));
    assign aw_push_rdy = ~full;
    assign outstanding = count;
    assign push_acc    = aw_push & aw_push_rdy;

    // Lowest set bit wins; an all-zero grant falls back to index 0.
    always_comb begin
        src_idx = '0;
        for (int i = N_INPUT - 1; i >= 0; i--) begin
            if (aw_src[i]) src_idx = IDX_W'(i);
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        head_oh = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            head_oh[i] = (head == IDX_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < N_INPUT; i++) begin
            slave_b[i] = master_b;
        end
    end

    assign slave_bvld  = {N_INPUT{master_bvld & ~empty}} & head_oh;
    assign master_brdy = ~empty & (|(head_oh & slave_brdy));
    assign pop         = master_bvld & master_brdy;

    always_ff @(posedge clkg) begin
        if (push_acc) mem[wr_ptr] <= src_idx;
    end

    always_ff @(posedge clkg) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push_acc && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_acc) begin
                count <= count - 1'b1;
            end
        end
    end

    // Both flags only set while clk_en is high, so the gated clock never misses them.
    always_ff @(posedge clkg) begin
        if (!rstn) begin
            err_unexp_b <= 1'b0;
            err_bad_src <= 1'b0;
        end else begin
            if (master_bvld && empty) err_unexp_b <= 1'b1;
            if (push_acc && !$onehot(aw_src)) err_bad_src <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ours_axi4_b_rr_resp_router.sv
// Bench for the B response router: directed scenarios then random traffic,
// every cycle compared against a queue-based model of outstanding writes.

module tb_ours_axi4_b_rr_resp_router;
    localparam int N    = 2;
    localparam int BW   = 2;
    localparam int MO   = 4;
    localparam int CW   = $clog2(MO + 1);

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   aw_push = 1'b0;
    logic [N-1:0]           aw_src = '0;
    logic                   aw_push_rdy;
    logic                   master_bvld = 1'b0;
    logic [BW-1:0]          master_b = '0;
    logic                   master_brdy;
    logic [N-1:0]           slave_bvld;
    logic [N-1:0][BW-1:0]   slave_b;
    logic [N-1:0]           slave_brdy = '1;
    logic [CW-1:0]          outstanding;
    logic                   err_unexp_b;
    logic                   err_bad_src;
    logic                   clk_en;

    int tests = 0;
    int fails = 0;

    int q[$];
    bit m_unexp;
    bit m_bad;

    always #5 clk = ~clk;

    ours_axi4_b_rr_resp_router #(
        .BACKEND_DOMAIN  (0),
        .N_INPUT         (N),
        .B_WIDTH         (BW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .aw_push     (aw_push),
        .aw_src      (aw_src),
        .aw_push_rdy (aw_push_rdy),
        .master_bvld (master_bvld),
        .master_b    (master_b),
        .master_brdy (master_brdy),
        .slave_bvld  (slave_bvld),
        .slave_b     (slave_b),
        .slave_brdy  (slave_brdy),
        .outstanding (outstanding),
        .err_unexp_b (err_unexp_b),
        .err_bad_src (err_bad_src),
        .clk_en      (clk_en)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, compare outputs against the model, then advance the model.
    task automatic step(input bit p, input logic [N-1:0] s, input bit v,
                        input logic [BW-1:0] b, input logic [N-1:0] r);
        bit          is_empty;
        bit          exp_brdy;
        logic [N-1:0] exp_bvld;
        int          idx;
        bit          do_pop;
        bit          do_push;
        @(negedge clk);
        aw_push = p; aw_src = s; master_bvld = v; master_b = b; slave_brdy = r;
        #1;
        is_empty = (q.size() == 0);
        exp_brdy = !is_empty && r[q[0]];
        exp_bvld = (v && !is_empty) ? N'(1 << q[0]) : '0;
        check_val("aw_push_rdy", 32'(aw_push_rdy), 32'(q.size() < MO));
        check_val("outstanding", 32'(outstanding), 32'(q.size()));
        check_val("master_brdy", 32'(master_brdy), 32'(exp_brdy));
        check_val("slave_bvld", 32'(slave_bvld), 32'(exp_bvld));
        check_val("slave_b", 32'(slave_b), 32'({N{b}}));
        check_val("err_unexp_b", 32'(err_unexp_b), 32'(m_unexp));
        check_val("err_bad_src", 32'(err_bad_src), 32'(m_bad));
        check_val("clk_en", 32'(clk_en), 32'(p || !is_empty || v));

        do_pop  = v && exp_brdy;
        do_push = p && (q.size() < MO);
        if (v && is_empty) m_unexp = 1'b1;
        if (do_push && $countones(s) != 1) m_bad = 1'b1;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (s[i]) idx = i;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(idx);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0; aw_push = 1'b0; aw_src = '0; master_bvld = 1'b0; slave_brdy = '1;
        #1;
        check_val("clk_en_in_reset", 32'(clk_en), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        q.delete();
        m_unexp = 1'b0;
        m_bad = 1'b0;
        #1;
        check_val("rst_outstanding", 32'(outstanding), 32'd0);
        check_val("rst_aw_push_rdy", 32'(aw_push_rdy), 32'd1);
        check_val("rst_master_brdy", 32'(master_brdy), 32'd0);
        check_val("rst_slave_bvld", 32'(slave_bvld), 32'd0);
        check_val("rst_errors", 32'({err_unexp_b, err_bad_src}), 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) step(0, '0, 1, BW'($urandom), '1);
        check_val("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        m_unexp = 1'b0;
        m_bad = 1'b0;
        reset_dut();

        // Basic in-order routing.
        step(1, 2'b01, 0, 0, '1);
        step(1, 2'b10, 0, 0, '1);
        step(1, 2'b01, 0, 0, '1);
        step(0, '0, 1, 2'd0, '1);
        step(0, '0, 1, 2'd2, '1);
        step(0, '0, 1, 2'd0, '1);
        step(0, '0, 0, 2'd0, '1);

        // Fill, overflow push ignored, slot freed only after the pop cycle.
        for (int i = 0; i < MO; i++) step(1, (i % 2) ? 2'b10 : 2'b01, 0, 0, '1);
        step(1, 2'b10, 0, 0, '1);
        step(1, 2'b10, 1, 2'd1, '1);
        step(0, '0, 0, 0, '1);
        drain();

        // Head-of-line blocking.
        step(1, 2'b01, 0, 0, '1);
        step(1, 2'b10, 0, 0, '1);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 2'd3, 2'b10);
        step(0, '0, 1, 2'd3, 2'b01);
        step(0, '0, 1, 2'd1, 2'b01);
        step(0, '0, 1, 2'd1, 2'b10);

        // Simultaneous push/pop across pointer wrap.
        step(1, 2'b10, 0, 0, '1);
        step(1, 2'b01, 0, 0, '1);
        for (int i = 0; i < 6; i++) step(1, (i % 3 == 0) ? 2'b01 : 2'b10, 1, BW'(i), '1);
        drain();

        // Unexpected B stalls until a write is tracked; no same-cycle bypass.
        step(0, '0, 1, 2'd2, '1);
        step(0, '0, 1, 2'd2, '1);
        step(1, 2'b10, 1, 2'd2, '1);
        step(0, '0, 1, 2'd2, '1);
        step(0, '0, 0, 0, '1);

        // Multi-hot grant routes to slave 0, then reset with writes outstanding.
        step(1, 2'b11, 0, 0, '1);
        step(0, '0, 1, 2'd1, '1);
        for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 0, '1);
        step(0, '0, 0, 0, '1);
        reset_dut();

        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] src;
            src = ($urandom_range(0, 19) == 0) ? N'($urandom) : (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
            if ($urandom_range(0, 99) == 0) reset_dut();
            else step($urandom_range(0, 2) != 0, src, $urandom_range(0, 2) != 0,
                      BW'($urandom), N'($urandom_range(0, 3)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ours_axi4_b_rr_resp_router.md
Name: ours_axi4_b_rr_resp_router

Overview:
- Downstream companion of the N-input AW/W round-robin arbiter buffer.
- The write path merges N write masters onto one AXI4 port without adding ID bits, so returned B responses cannot be steered by ID.
- This block records the granted source of every accepted AW in an in-order tracking FIFO and routes each returning B beat to that source.
- It also bounds outstanding writes by back-pressuring the arbiter's AW push.

Parameters:
- BACKEND_DOMAIN, 0, passed to icg.
- N_INPUT, 2, number of upstream write masters; must be >=1.
- B_WIDTH, 2, width of the B payload (bresp, plus any user bits).
- MAX_OUTSTANDING, 4, tracking FIFO depth; must be >=1. CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- aw_push  input  1  an AW handshake occurred at the arbiter output this cycle
- aw_src  input  N_INPUT  one-hot grant of the AW being pushed
- aw_push_rdy  output  1  tracking FIFO can accept a push; the arbiter ANDs this into its AW ready
- master_bvld  input  1  B valid from downstream
- master_b  input  B_WIDTH  B payload from downstream
- master_brdy  output  1  B ready to downstream
- slave_bvld  output  N_INPUT  per-source B valid
- slave_b  output  N_INPUT x B_WIDTH  per-source B payload (broadcast)
- slave_brdy  input  N_INPUT  per-source B ready
- outstanding  output  CNT_W  current FIFO occupancy
- err_unexp_b  output  1  sticky: B arrived with no outstanding write
- err_bad_src  output  1  sticky: aw_push seen with non-one-hot aw_src
- clk_en  output  1  clock-gate request

Behaviour:
- Reset (rstn=0 at posedge):
  - FIFO empty; outstanding=0; aw_push_rdy=1; errors=0.
  - Outputs are derived combinationally from that state, so master_brdy=0 and slave_bvld=0.
- FIFO storage:
  - Circular buffer of encoded source indices ($clog2(N_INPUT) bits, minimum 1).
  - Read/write pointers wrap from MAX_OUTSTANDING-1 to 0; non-power-of-2 depth is supported.
  - Full/empty are derived from the registered count.
- Push:
  - Accepted when aw_push & aw_push_rdy.
  - aw_push_rdy = ~full, from registered state only. A pop in the same cycle does not free a slot for a push in that cycle.
  - aw_push while full: ignored, nothing stored (arbiter protocol violation; no flag).
  - Non-one-hot aw_src (zero or multiple bits) on an accepted push: the entry is stored as the lowest set bit, or index 0 if none, and err_bad_src sets.
- Routing (combinational from FIFO head):
  - head_oh = decode(head). slave_b[i] = master_b for all i.
  - slave_bvld[i] = master_bvld & ~empty & head_oh[i].
  - master_brdy = ~empty & |(head_oh & slave_brdy).
  - Pop on master_bvld & master_brdy.
- Latency: an entry pushed in cycle t can route B no earlier than cycle t+1. There is no push-to-pop bypass; with the FIFO empty, a same-cycle push and B do not pop.
- Occupancy:
  - outstanding += push_acc, -= pop, evaluated simultaneously.
  - Simultaneous push and pop: count is unchanged, both pointers advance.
- Errors:
  - master_bvld while empty: err_unexp_b sets; master_brdy stays 0 (the B is stalled, not dropped).
  - Both error flags clear only on reset.
- Back-pressure: the head source's slave_brdy=0 stalls all B traffic, including B for other sources, to preserve order.
- clk_en = ~rstn | aw_push | ~empty | master_bvld.
  - All state registers are clocked by clkg from icg (tst_en=0).
  - The err flags are also on clkg; this is safe because they only set when clk_en is high.
- Reset mid-operation: all outstanding entries are discarded. Upstream and downstream must be reset together.
- N_INPUT=1: routing degenerates to pass-through gated by ~empty; the FIFO still counts outstanding writes.

Test Plan:
- Reset, then N_INPUT=2, depth 4: push src 01, 10, 01; return 3 B with bresp 0,2,0, all brdy=1 -> slave_bvld sequence 01,10,01 on cycles 1-3 after the first B; slave_b carries 0,2,0; outstanding 3->0.
- Fill 4 entries -> aw_push_rdy=0, outstanding=4. A 5th push is ignored. One B pop -> aw_push_rdy=1 the next cycle, not the same cycle.
- Head src 0 with slave_brdy=2'b10 and master_bvld=1 held 5 cycles -> master_brdy=0 and no pop throughout. slave_brdy[0]=1 -> one pop, head advances to the next entry.
- With 2 outstanding, push and pop in the same cycle -> outstanding stays 2; 6 iterations exercise pointer wrap; routing order preserved.
- master_bvld=1 with FIFO empty -> master_brdy=0, err_unexp_b=1 from the next cycle. A later push lets that B route; err_unexp_b stays 1 until rstn=0.
- aw_push with aw_src=2'b11 -> err_bad_src=1 and the entry routes to slave 0. Reset asserted with 3 outstanding -> outstanding=0, aw_push_rdy=1, both error flags clear.
